stage_if_id_buffer: RTL and testbench
=====================================

Name: stage_if_id_buffer

Overview:
- Elastic pipeline buffer directly downstream of the instruction-fetch stage. It feeds the decode stage.
- Captures each fetched instruction word (IR) together with its PC+2 value.
- Holds up to DEPTH entries in FIFO order with a valid/ready handshake on both sides, so decode stalls back-pressure fetch without dropping instructions.
- A flush input discards all buffered and incoming instructions on a control-flow redirect (branch, JSR, JMP, TRAP).

Parameters:
- DEPTH, 2, number of entries; legal values are powers of two, 2 to 8.
- WIDTH, 16, width of the IR and PC+2 fields; lc3b_word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_valid  input  1  fetch stage presents a valid instruction this cycle (instruction memory ACK).
- if_ir_in  input  WIDTH  fetched instruction word.
- if_pc_plus2_in  input  WIDTH  PC+2 of the fetched instruction.
- if_ready  output  1  buffer can accept an instruction this cycle; fetch must hold its PC when low.
- id_valid  output  1  head entry is valid for decode.
- id_ir_out  output  WIDTH  head entry instruction word.
- id_pc_plus2_out  output  WIDTH  head entry PC+2.
- id_ready  input  1  decode consumes the head entry this cycle.
- flush  input  1  synchronous discard of all contents.
- occupancy  output  clog2(DEPTH)+1  current entry count, for debug and stall logic.

Behaviour:
- Interface (already decided): one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset, asserted asynchronously:
  - count=0, read and write pointers=0, all storage=0.
  - id_valid=0, id_ir_out=0, id_pc_plus2_out=0, if_ready=1, occupancy=0.
- Handshake events:
  - push = if_valid & if_ready & ~flush.
  - pop = id_valid & id_ready & ~flush.
- Storage is a circular array of DEPTH entries {ir, pc_plus2}.
  - Write pointer advances on push; read pointer advances on pop. Both wrap modulo DEPTH.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Outputs:
  - id_valid = (count != 0).
  - id_ir_out and id_pc_plus2_out = storage[read pointer], taken from registered state (no combinational input-to-output path).
  - if_ready = (count != DEPTH), from registered count only.
  - When full, if_ready=0 even if a pop occurs in the same cycle; a slot frees one cycle later.
- Latency: an instruction pushed in cycle N is visible at the outputs with id_valid=1 in cycle N+1. There is no bypass.
- Empty: pop is impossible because id_valid=0. id_ready is ignored.
- Full: if_valid is ignored and nothing is written. Fetch is responsible for holding its PC.
- Flush, synchronous, highest priority:
  - Next cycle: count=0, both pointers=0, id_valid=0, if_ready=1.
  - Any same-cycle if_valid and id_ready are ignored.
  - Storage contents need not be cleared.
- Flush held for multiple cycles: the buffer stays empty throughout.
- Reset asserted mid-operation: immediate return to reset values regardless of clk. The first push is accepted on the first rising edge after reset_n deasserts.

Optional Feature:
- Macro: IF_ID_BUBBLE_NOP_EN.
- Defined: while id_valid=0, id_ir_out is forced to 16'h0000 (LC-3b BR with nzp=000, an architectural NOP) and id_pc_plus2_out to 0. Decode can then treat bubbles as NOPs without checking id_valid.
- Undefined: id_ir_out and id_pc_plus2_out show storage[read pointer] unconditionally. Contents are stale when empty, and consumers must qualify them with id_valid.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> outputs immediately id_valid=0, if_ready=1, occupancy=0, id_ir_out=0.
- Single pass-through: push ir=16'h1234, pc_plus2=16'h0002 in cycle 0 with id_ready=1 -> cycle 1: id_valid=1, id_ir_out=16'h1234. Cycle 2: id_valid=0.
- Fill and back-pressure (DEPTH=2): id_ready=0, push 16'hA001 then 16'hA002 -> occupancy=2, if_ready=0. Third push 16'hA003 is ignored. Release id_ready -> pops 16'hA001 then 16'hA002 in order, and 16'hA003 never appears.
- Simultaneous push and pop at occupancy=1: count stays 1, and order is preserved across pointer wrap over 6 sequential instructions 16'h0100 to 16'h0105.
- Flush: occupancy=2, flush=1 with if_valid=1 (ir=16'hBEEF) and id_ready=1 -> next cycle occupancy=0, id_valid=0. 16'hBEEF is never output, and the next push after flush is output first.
- Bubble NOP: with IF_ID_BUBBLE_NOP_EN defined and the buffer empty after popping 16'hFFFF -> id_ir_out=16'h0000. Without the macro -> id_ir_out=16'hFFFF with id_valid=0.

Source files
------------

// File: rtl/stage_if_id_buffer.sv
// Elastic IF->ID buffer: DEPTH-entry FIFO of {ir, pc_plus2} with valid/ready on both sides and synchronous flush.
// Optional macro IF_ID_BUBBLE_NOP_EN forces NOP/zero outputs while the buffer is empty.
module stage_if_id_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       if_valid,
    input  logic [WIDTH-1:0]           if_ir_in,
    input  logic [WIDTH-1:0]           if_pc_plus2_in,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [WIDTH-1:0]           id_ir_out,
    output logic [WIDTH-1:0]           id_pc_plus2_out,
    input  logic                       id_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] ir_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop;

    // Status derived from registered count only; no input-to-output path.
    assign id_valid  = (count != '0);
    assign if_ready  = (count != CNT_W'(DEPTH));
    assign occupancy = count;

    // Handshake decode and next-state; flush overrides everything.
    always_comb begin
        push       = if_valid & if_ready & ~flush;
        pop        = id_valid & id_ready & ~flush;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Entry storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ir_mem[i] <= '0;
                pc_mem[i] <= '0;
            end
        end else if (push) begin
            ir_mem[wr_ptr] <= if_ir_in;
            pc_mem[wr_ptr] <= if_pc_plus2_in;
        end
    end

`ifdef IF_ID_BUBBLE_NOP_EN
    // Bubbles read as BR nzp=000, an architectural NOP.
    assign id_ir_out       = id_valid ? ir_mem[rd_ptr] : '0;
    assign id_pc_plus2_out = id_valid ? pc_mem[rd_ptr] : '0;
`else
    assign id_ir_out       = ir_mem[rd_ptr];
    assign id_pc_plus2_out = pc_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_stage_if_id_buffer.sv
// Scoreboard bench for stage_if_id_buffer: a queue model tracks expected contents and every cycle's outputs.
module tb_stage_if_id_buffer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             if_valid = 1'b0;
    logic [WIDTH-1:0] if_ir_in = '0;
    logic [WIDTH-1:0] if_pc_plus2_in = '0;
    logic             if_ready;
    logic             id_valid;
    logic [WIDTH-1:0] id_ir_out;
    logic [WIDTH-1:0] id_pc_plus2_out;
    logic             id_ready = 1'b0;
    logic             flush = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    stage_if_id_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_valid        (if_valid),
        .if_ir_in        (if_ir_in),
        .if_pc_plus2_in  (if_pc_plus2_in),
        .if_ready        (if_ready),
        .id_valid        (id_valid),
        .id_ir_out       (id_ir_out),
        .id_pc_plus2_out (id_pc_plus2_out),
        .id_ready        (id_ready),
        .flush           (flush),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        int n = sb.size();
        logic [31:0] head;
        check("id_valid", 32'(id_valid), 32'(n != 0));
        check("if_ready", 32'(if_ready), 32'(n != int'(DEPTH)));
        check("occupancy", 32'(occupancy), 32'(n));
        if (n != 0) begin
            head = sb[0];
            check("id_ir_out", 32'(id_ir_out), 32'(head[31:16]));
            check("id_pc_plus2_out", 32'(id_pc_plus2_out), 32'(head[15:0]));
        end
`ifdef IF_ID_BUBBLE_NOP_EN
        else begin
            check("bubble_ir", 32'(id_ir_out), 32'h0);
            check("bubble_pc", 32'(id_pc_plus2_out), 32'h0);
        end
`endif
    endtask

    task automatic model_update(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                                input logic rdy, input logic fl);
        int n = sb.size();
        if (fl) begin
            sb.delete();
        end else begin
            if (n != 0 && rdy) void'(sb.pop_front());
            if (v && n != int'(DEPTH)) sb.push_back({ir, pc});
        end
    endtask

    // Drive one cycle: inputs after the rising edge, check and model at the falling edge.
    task automatic step(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                        input logic rdy, input logic fl);
        if_valid       = v;
        if_ir_in       = ir;
        if_pc_plus2_in = pc;
        id_ready       = rdy;
        flush          = fl;
        @(negedge clk);
        compare_outputs();
        model_update(v, ir, pc, rdy, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_id_valid"}, 32'(id_valid), 32'h0);
        check({tag, "_if_ready"}, 32'(if_ready), 32'h1);
        check({tag, "_occupancy"}, 32'(occupancy), 32'h0);
        check({tag, "_id_ir_out"}, 32'(id_ir_out), 32'h0);
        check({tag, "_id_pc_out"}, 32'(id_pc_plus2_out), 32'h0);
    endtask

    initial begin
        // Reset asserted mid-cycle, outputs must react without a clock edge.
        #3 reset_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pass-through
        step(1'b1, 16'h1234, 16'h0002, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Fill and back-pressure; third push must be dropped
        step(1'b1, 16'hA001, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'hA002, 16'h0012, 1'b0, 1'b0);
        step(1'b1, 16'hA003, 16'h0014, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Simultaneous push/pop at occupancy 1 across pointer wrap
        step(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++)
            step(1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(2 * i), 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Flush while full with same-cycle push and pop
        step(1'b1, 16'hB001, 16'h0030, 1'b0, 1'b0);
        step(1'b1, 16'hB002, 16'h0032, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 16'h0034, 1'b1, 1'b1);
        step(1'b1, 16'hC001, 16'h0040, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Flush held for several cycles
        step(1'b1, 16'hD001, 16'h0050, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'hD100 + 16'(i), 16'h0060, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Bubble: both slots hold FFFF, then drain
        step(1'b1, 16'hFFFF, 16'h0070, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 16'h0072, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef IF_ID_BUBBLE_NOP_EN
        check("bubble_nop", 32'(id_ir_out), 32'h0000);
`else
        check("bubble_stale", 32'(id_ir_out), 32'hFFFF);
`endif
        check("bubble_valid", 32'(id_valid), 32'h0);

        // Reset mid-operation, then first push right after release
        step(1'b1, 16'hE001, 16'h0080, 1'b0, 1'b0);
        step(1'b1, 16'hE002, 16'h0082, 1'b0, 1'b0);
        if_valid = 1'b0;
        reset_n  = 1'b0;
        #1 check_reset_values("midreset");
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 16'hE100, 16'h0090, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
